capture_ctrl: RTL

//  Sequences one logic-analyzer acquisition. Gates per-sample RAM writes (wrt_smpl from clk_rst_smpl) for the 5 sampler_reg channels.

---
 rtl/la_pkg.sv | 14 +
 rtl/capture_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer types: capture FSM state encoding and default RAM address width.
package la_pkg;

  localparam int unsigned ADDR_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: fills the pre-trigger window, arms the trigger logic,
// captures the post-trigger samples and reports the oldest-sample address.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clr_done,
  input  logic              wrt_smpl,
  input  logic              triggered,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              set_armed,
  output logic              armed,
  output logic              capture_done,
  output logic [ADDR_W-1:0] start_addr
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [CNT_W-1:0]  smpl_cnt_q, smpl_cnt_d;
  logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]  run_pos_q, run_pos_d;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      waddr_q      <= '0;
      start_addr_q <= '0;
      smpl_cnt_q   <= '0;
      post_cnt_q   <= '0;
      run_pos_q    <= '0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      start_addr_q <= start_addr_d;
      smpl_cnt_q   <= smpl_cnt_d;
      post_cnt_q   <= post_cnt_d;
      run_pos_q    <= run_pos_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    start_addr_d = start_addr_q;
    smpl_cnt_d   = smpl_cnt_q;
    post_cnt_d   = post_cnt_q;
    run_pos_d    = run_pos_q;

    if (we) waddr_d = waddr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = PRE;
          waddr_d    = '0;
          smpl_cnt_d = '0;
          post_cnt_d = '0;
          // trig_pos is ADDR_W wide, so it never exceeds DEPTH-1
          run_pos_d  = CNT_W'(trig_pos);
        end
      end
      PRE: begin
        if (we) begin
          smpl_cnt_d = smpl_cnt_q + CNT_W'(1);
          if (smpl_cnt_d == CNT_W'(DEPTH) - run_pos_q) state_d = ARMED;
        end
      end
      ARMED: begin
        // A write coinciding with the trigger still belongs to the pre-trigger window
        if (triggered) begin
          post_cnt_d = '0;
          if (run_pos_q == '0) begin
            state_d      = DONE;
            start_addr_d = waddr_d;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (we) begin
          post_cnt_d = post_cnt_q + CNT_W'(1);
          if (post_cnt_d == run_pos_q) begin
            state_d      = DONE;
            start_addr_d = waddr_d;
          end
        end
      end
      DONE: begin
        if (clr_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    we           = 1'b0;
    set_armed    = 1'b0;
    armed        = 1'b0;
    capture_done = 1'b0;
    waddr        = waddr_q;
    start_addr   = start_addr_q;
    if (!rst) begin
      we        = wrt_smpl && (state_q == PRE || state_q == ARMED || state_q == POST);
      set_armed = (state_q == PRE) && (state_d == ARMED);
    end
    armed        = (state_q == ARMED);
    capture_done = (state_q == DONE);
  end

endmodule
